spike_weight_dispatcher: RTL and testbench

//  Drives the din/data_ready/boot_mode inputs of N_OUT hidden_layer-style LIF neurons.
//  - Each snn_clk tick: captures the previous layer's spike vector.
//  - For every spiking input i, emits weight row i (one signed 16-bit word per neuron lane).
//  - Boot: emits the bias row once, with boot_mode high.
//  - Holds weights and biases in an internal register file, written via a simple config port.

---
 rtl/spike_weight_dispatcher.sv | 158 +++++++++++++++
 tb/tb_spike_weight_dispatcher.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_weight_dispatcher.sv
// Streams signed weight rows to a bank of LIF neuron lanes for every spike in the
// captured input vector, plus a one-shot bias row at boot. Optional macro: SKIP_ZERO_EN.
module spike_weight_dispatcher #(
   parameter int unsigned N_IN  = 8,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned AW    = 4
) (
   input  logic                 sys_clk_i,
   input  logic                 rst_i,
   input  logic                 snn_clk_i,
   input  logic [N_IN-1:0]      spikes_in_i,
   input  logic                 wr_en_i,
   input  logic [AW-1:0]        wr_addr_i,
   input  logic [16*N_OUT-1:0]  wr_data_i,
   input  logic                 boot_req_i,
   output logic [16*N_OUT-1:0]  din_o,
   output logic                 data_ready_o,
   output logic                 boot_mode_o,
   output logic                 busy_o,
   output logic                 overrun_o
);

   localparam int unsigned RowW = 16 * N_OUT;

   typedef enum logic [1:0] {StIdle, StCapture, StScan, StBoot} state_e;

   state_e            state_q;
   logic [AW-1:0]     idx_q;
   logic [N_IN-1:0]   spk_q;
   logic [RowW-1:0]   rows_q [N_IN+1];
   logic [RowW-1:0]   din_q;
   logic              dr_q;
   logic              boot_q;
   logic              busy_q;
   logic              ovr_q;

   logic [AW-1:0]     first_idx;
   logic              first_bit;
   logic [AW-1:0]     next_idx;
   logic              next_bit;
   logic              more;
   logic              wr_ok;
   logic [RowW-1:0]   bias_row;

   // Scan sequencing: where a scan starts and which row follows the current one.
`ifdef SKIP_ZERO_EN
   always_comb begin
      first_idx = '0;
      first_bit = 1'b0;
      next_idx  = idx_q;
      next_bit  = 1'b0;
      more      = 1'b0;
      for (int i = int'(N_IN) - 1; i >= 0; i--) begin
         if (spikes_in_i[i]) begin
            first_idx = AW'(i);
            first_bit = 1'b1;
         end
         if (spk_q[i] && (AW'(i) > idx_q)) begin
            next_idx = AW'(i);
            next_bit = 1'b1;
            more     = 1'b1;
         end
      end
   end
`else
   always_comb begin
      first_idx = '0;
      first_bit = spikes_in_i[0];
      next_idx  = idx_q + AW'(1);
      more      = (idx_q != AW'(N_IN - 1));
      next_bit  = 1'b0;
      for (int i = 0; i < int'(N_IN); i++) begin
         if (AW'(i) == next_idx) next_bit = spk_q[i];
      end
   end
`endif

   assign wr_ok = wr_en_i && (state_q == StIdle) && (wr_addr_i <= AW'(N_IN));
   // A bias write in the same cycle as boot_req must reach the boot emission.
   assign bias_row = (wr_ok && (wr_addr_i == AW'(N_IN))) ? wr_data_i : rows_q[N_IN];

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         idx_q   <= '0;
         spk_q   <= '0;
         din_q   <= '0;
         dr_q    <= 1'b0;
         boot_q  <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         for (int r = 0; r <= int'(N_IN); r++) rows_q[r] <= '0;
      end else begin
         if (wr_ok) rows_q[wr_addr_i] <= wr_data_i;
         unique case (state_q)
            StIdle: begin
               dr_q   <= 1'b0;
               boot_q <= 1'b0;
               if (snn_clk_i) begin
                  state_q <= StCapture;
                  busy_q  <= 1'b1;
               end else if (boot_req_i) begin
                  state_q <= StBoot;
                  busy_q  <= 1'b1;
                  din_q   <= bias_row;
                  dr_q    <= 1'b1;
                  boot_q  <= 1'b1;
               end
            end
            StCapture: begin
               spk_q <= spikes_in_i;
               if (snn_clk_i) begin
                  ovr_q <= 1'b1;
                  dr_q  <= 1'b0;
               end else begin
                  state_q <= StScan;
                  idx_q   <= first_idx;
                  dr_q    <= first_bit;
                  if (first_bit) din_q <= rows_q[first_idx];
               end
            end
            StScan: begin
               if (snn_clk_i) begin
                  ovr_q   <= 1'b1;
                  dr_q    <= 1'b0;
                  state_q <= StCapture;
               end else if (more) begin
                  idx_q <= next_idx;
                  dr_q  <= next_bit;
                  if (next_bit) din_q <= rows_q[next_idx];
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
                  dr_q    <= 1'b0;
               end
            end
            StBoot: begin
               dr_q   <= 1'b0;
               boot_q <= 1'b0;
               // A tick landing on the boot cycle is still served rather than lost.
               if (snn_clk_i) begin
                  state_q <= StCapture;
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign din_o        = din_q;
   assign data_ready_o = dr_q & ~snn_clk_i;
   assign boot_mode_o  = boot_q;
   assign busy_o       = busy_q;
   assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_spike_weight_dispatcher.sv
// Randomized bench for spike_weight_dispatcher: a per-cycle expectation timeline is
// scheduled from each tick/boot/reset event and compared every cycle.
module tb_spike_weight_dispatcher;

   localparam int unsigned NIn    = 8;
   localparam int unsigned NOut   = 4;
   localparam int unsigned Aw     = 4;
   localparam int unsigned RowW   = 16 * NOut;
   localparam int          MaxCyc = 2000;

   logic              clk = 1'b0;
   logic              rst;
   logic              snn_clk;
   logic [NIn-1:0]    spikes;
   logic              wr_en;
   logic [Aw-1:0]     wr_addr;
   logic [RowW-1:0]   wr_data;
   logic              boot_req;
   logic [RowW-1:0]   din;
   logic              data_ready;
   logic              boot_mode;
   logic              busy;
   logic              overrun;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   bit              exp_busy [MaxCyc];
   bit              exp_dr   [MaxCyc];
   bit              exp_boot [MaxCyc];
   bit              exp_ovr  [MaxCyc];
   logic [RowW-1:0] exp_din  [MaxCyc];
   logic [RowW-1:0] mrow     [NIn+1];

   spike_weight_dispatcher #(
      .N_IN  (NIn),
      .N_OUT (NOut),
      .AW    (Aw)
   ) u_dut (
      .sys_clk_i    (clk),
      .rst_i        (rst),
      .snn_clk_i    (snn_clk),
      .spikes_in_i  (spikes),
      .wr_en_i      (wr_en),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .boot_req_i   (boot_req),
      .din_o        (din),
      .data_ready_o (data_ready),
      .boot_mode_o  (boot_mode),
      .busy_o       (busy),
      .overrun_o    (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [RowW-1:0] obs, input logic [RowW-1:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
      end
   endtask

   // A tick drops whatever was pending and schedules a fresh capture + scan.
   task automatic model_tick(input int c, input logic [NIn-1:0] spk);
      bit late;
      int n;
      late = exp_busy[c] && !exp_boot[c];
      for (int k = c; k < MaxCyc; k++) begin
         exp_dr[k] = 1'b0;
         if (k > c) begin
            exp_busy[k] = 1'b0;
            exp_boot[k] = 1'b0;
         end
      end
      if (late) for (int k = c + 1; k < MaxCyc; k++) exp_ovr[k] = 1'b1;
      exp_busy[c+1] = 1'b1;
      n = 0;
`ifdef SKIP_ZERO_EN
      for (int i = 0; i < int'(NIn); i++) begin
         if (spk[i]) begin
            exp_dr[c+2+n]  = 1'b1;
            exp_din[c+2+n] = mrow[i];
            n++;
         end
      end
      if (n == 0) n = 1;
`else
      n = NIn;
      for (int i = 0; i < int'(NIn); i++) begin
         if (spk[i]) begin
            exp_dr[c+2+i]  = 1'b1;
            exp_din[c+2+i] = mrow[i];
         end
      end
`endif
      for (int j = 0; j < n; j++) exp_busy[c+2+j] = 1'b1;
   endtask

   task automatic step(input bit r, input bit t, input bit b, input bit w,
                       input logic [Aw-1:0] a, input logic [RowW-1:0] d,
                       input logic [NIn-1:0] s);
      rst      = r;
      snn_clk  = t;
      boot_req = b;
      wr_en    = w;
      wr_addr  = a;
      wr_data  = d;
      if (t) spikes = s;
      if (r) begin
         for (int k = cyc + 1; k < MaxCyc; k++) begin
            exp_busy[k] = 1'b0;
            exp_dr[k]   = 1'b0;
            exp_boot[k] = 1'b0;
            exp_ovr[k]  = 1'b0;
         end
         for (int i = 0; i <= int'(NIn); i++) mrow[i] = '0;
      end else begin
         if (w && !exp_busy[cyc] && (a <= NIn)) mrow[a] = d;
         if (t) begin
            model_tick(cyc, s);
         end else if (b && !exp_busy[cyc]) begin
            exp_busy[cyc+1] = 1'b1;
            exp_dr[cyc+1]   = 1'b1;
            exp_boot[cyc+1] = 1'b1;
            exp_din[cyc+1]  = mrow[NIn];
         end
      end
      @(negedge clk);
      check("data_ready", RowW'(data_ready), RowW'(exp_dr[cyc]));
      check("boot_mode", RowW'(boot_mode), RowW'(exp_boot[cyc]));
      check("busy", RowW'(busy), RowW'(exp_busy[cyc]));
      check("overrun", RowW'(overrun), RowW'(exp_ovr[cyc]));
      if (exp_dr[cyc]) check("din", din, exp_din[cyc]);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic wr(input logic [Aw-1:0] a, input logic [RowW-1:0] d);
      step(1'b0, 1'b0, 1'b0, 1'b1, a, d, '0);
   endtask

   task automatic tick(input logic [NIn-1:0] s);
      step(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, s);
   endtask

   initial begin
      bit              r_t, r_b, r_w, r_r;
      logic [Aw-1:0]   r_a;
      logic [RowW-1:0] r_d;
      logic [NIn-1:0]  r_s;

      for (int i = 0; i <= int'(NIn); i++) mrow[i] = '0;
      rst = 1'b1; snn_clk = 1'b0; boot_req = 1'b0; wr_en = 1'b0;
      wr_addr = '0; wr_data = '0; spikes = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_din", din, '0);
      @(posedge clk);
      #1;

      // Single spike on row 3.
      wr(4'd3, {4{16'sd25}});
      tick(8'b0000_1000);
      idle(12);
      // Signed lane-0 values on rows 0 and 7.
      wr(4'd0, {48'd0, 16'hFFF9});
      wr(4'd7, {48'd0, 16'd100});
      tick(8'h81);
      idle(12);
      // Bias row boot, then boot_req coincident with a tick.
      wr(4'd8, {16'sd1, 16'sd2, 16'sd3, 16'sd4});
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0);
      idle(3);
      step(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 8'h00);
      idle(12);
      // Overrun: second tick four cycles after the first.
      tick(8'hFF);
      idle(3);
      tick(8'hFF);
      idle(12);
      // Write to row 2 during a scan is dropped.
      tick(8'h04);
      idle(2);
      wr(4'd2, 64'hDEAD_BEEF_0123_4567);
      idle(10);
      tick(8'h04);
      idle(12);
      // Two sparse spikes, then reset in the middle of a scan.
      tick(8'b0100_0100);
      idle(12);
      tick(8'hFF);
      idle(4);
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      idle(12);

      while (cyc < MaxCyc - 30) begin
         r_t = 1'b0; r_b = 1'b0; r_r = 1'b0;
         r_w = ($urandom_range(0, 3) == 0);
         r_a = Aw'($urandom_range(0, 15));
         r_d = {$urandom, $urandom};
         case ($urandom_range(0, 5))
            0:       r_s = '0;
            1:       r_s = '1;
            default: r_s = NIn'($urandom);
         endcase
         if (!exp_busy[cyc]) begin
            case ($urandom_range(0, 9))
               0, 1, 2: r_t = 1'b1;
               3:       r_b = 1'b1;
               4:       begin r_t = 1'b1; r_b = 1'b1; end
               default: ;
            endcase
         end else if (!exp_boot[cyc] && ($urandom_range(0, 39) == 0)) begin
            r_t = 1'b1;
         end
         if ($urandom_range(0, 299) == 0) begin
            r_r = 1'b1; r_t = 1'b0; r_b = 1'b0;
         end
         step(r_r, r_t, r_b, r_w, r_a, r_d, r_s);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
